// File: rtl/flatten_fc_ibuf.sv
// Frame input buffer ahead of the flatten-to-FC CIM controller; serves bit-plane slices of a flattened feature map.
// Define FLATTEN_IBUF_DBUF_EN for two ping-pong banks; by default there is a single bank.
module flatten_fc_ibuf #(
  parameter int DATA_SIZE       = 8,
  parameter int INPUT_CHANNELS  = 16,
  parameter int IMG_SIZE        = 784,
  parameter int XBAR_SIZE       = 128,
  parameter int BUS_WIDTH       = 16,
  parameter int V_CIM_TILES_OUT = (INPUT_CHANNELS * IMG_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int NUM_ADDR        = (XBAR_SIZE + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int COUNT_WIDTH     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  parameter int ADDR_WIDTH      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_we,
  input  logic [INPUT_CHANNELS*DATA_SIZE-1:0]    i_data,
  output logic                                   o_ready,
  output logic                                   o_frame_valid,
  input  logic                                   i_release,
  input  logic [ADDR_WIDTH-1:0]                  i_addr,
  input  logic [COUNT_WIDTH-1:0]                 i_count,
  output logic [V_CIM_TILES_OUT*BUS_WIDTH-1:0]   o_data,
  output logic                                   o_overflow
);

  localparam int E      = INPUT_CHANNELS * IMG_SIZE;
  localparam int WORD_W = INPUT_CHANNELS * DATA_SIZE;
  localparam int PW     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int BIW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
`ifdef FLATTEN_IBUF_DBUF_EN
  localparam int NBANK  = 2;
`else
  localparam int NBANK  = 1;
`endif

  logic [PW-1:0]     wp;
  logic [NBANK-1:0]  full;
  logic [NBANK-1:0]  full_n;
  logic              wbank;
  logic              rbank;
  logic              overflow;
  logic              accept;
  logic              last;
  logic              rel;
  logic [WORD_W-1:0] mem [NBANK][IMG_SIZE];

  assign accept        = i_we && o_ready;
  assign last          = (wp == PW'(IMG_SIZE - 1));
  assign rel           = i_release && o_frame_valid;
  assign o_ready       = !full[wbank];
  assign o_frame_valid = full[rbank];
  assign o_overflow    = overflow;

  // Release and frame completion never target the same bank: one needs it full, the other empty.
  always_comb begin
    full_n = full;
    if (rel)
      full_n[rbank] = 1'b0;
    if (accept && last)
      full_n[wbank] = 1'b1;
  end

`ifdef FLATTEN_IBUF_DBUF_EN
  logic wbank_n;
  logic rbank_n;

  // Writer moves off a full bank when the other is free; reader moves off an empty bank when the other is full.
  always_comb begin
    wbank_n = (full_n[wbank] && !full_n[~wbank]) ? ~wbank : wbank;
    rbank_n = (!full_n[rbank] && full_n[~rbank]) ? ~rbank : rbank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      wbank <= wbank_n;
      rbank <= rbank_n;
    end
  end
`else
  assign wbank = 1'b0;
  assign rbank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_n;
      if (accept)
        wp <= last ? '0 : wp + 1'b1;
      if (i_we && !o_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wbank][wp] <= i_data;
  end

  // Zero-latency bit-plane read: one lane per tile row slot, zero for padding or out-of-range bits.
  for (genvar t = 0; t < V_CIM_TILES_OUT; t++) begin : g_tile
    for (genvar l = 0; l < BUS_WIDTH; l++) begin : g_lane
      int   row;
      int   e;
      logic hit;
      logic sel;

      always_comb begin
        row = int'(i_addr) * BUS_WIDTH + l;
        e   = t * XBAR_SIZE + row;
        hit = (row < XBAR_SIZE) && (e < E) && (int'(i_count) < DATA_SIZE);
        sel = hit ? mem[rbank][PW'(e / INPUT_CHANNELS)]
                       [BIW'((e % INPUT_CHANNELS) * DATA_SIZE + int'(i_count))] : 1'b0;
      end

      assign o_data[t*BUS_WIDTH + l] = sel;
    end
  end

endmodule
